// File: rtl/glyph_blitter.sv
// Character blitter: fetches each glyph row from a synchronous font ROM and
// streams one pixel per cycle (x, y, colour, plot) to a VGA adapter.
module glyph_blitter #(
  parameter int GLYPH_W     = 8,
  parameter int GLYPH_H     = 8,
  parameter int CHAR_W      = 5,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int TRANSPARENT = 0,
  localparam int ROW_W      = $clog2(GLYPH_H),
  localparam int ADDR_W     = CHAR_W + ROW_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic [CHAR_W-1:0]   char_id,
  input  logic [X_W-1:0]      origin_x,
  input  logic [Y_W-1:0]      origin_y,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                delete,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [GLYPH_W-1:0]  rom_data,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  localparam int COL_W = $clog2(GLYPH_W);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DRAW, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [GLYPH_W-1:0]  shift_q, shift_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic [X_W-1:0]      ox_q, ox_d;
  logic [Y_W-1:0]      oy_q, oy_d;
  logic [COLOUR_W-1:0] fg_q, fg_d, bg_q, bg_d;
  logic                del_q, del_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic                pix_en, pix_bit;
  logic [COL_W-1:0]    pix_col;

  function automatic logic [ADDR_W-1:0] row_addr(input logic [CHAR_W-1:0] c,
                                                 input logic [ROW_W-1:0]  r);
    return ADDR_W'(c) * ADDR_W'(GLYPH_H) + ADDR_W'(r);
  endfunction

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    shift_d    = shift_q;
    char_d     = char_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    del_d      = del_q;
    rom_addr_d = rom_addr_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pix_en     = 1'b0;
    pix_bit    = 1'b0;
    pix_col    = '0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          char_d     = char_id;
          ox_d       = origin_x;
          oy_d       = origin_y;
          fg_d       = fg_colour;
          bg_d       = bg_colour;
          del_d      = delete;
          row_d      = '0;
          rom_addr_d = row_addr(char_id, '0);
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // Pixel 0 comes straight from the ROM so the first plot is not delayed.
        pix_en  = 1'b1;
        pix_bit = rom_data[GLYPH_W-1];
        shift_d = rom_data << 1;
        col_d   = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (col_q == COL_W'(GLYPH_W - 1)) begin
          if (row_q == ROW_W'(GLYPH_H - 1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            row_d      = row_q + ROW_W'(1);
            rom_addr_d = row_addr(char_q, row_q + ROW_W'(1));
            state_d    = S_FETCH;
          end
        end else begin
          pix_en  = 1'b1;
          pix_bit = shift_q[GLYPH_W-1];
          pix_col = col_q + COL_W'(1);
          shift_d = shift_q << 1;
          col_d   = col_q + COL_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pix_en) begin
      x_d      = ox_q + X_W'(pix_col);
      y_d      = oy_q + Y_W'(row_q);
      colour_d = (del_q || !pix_bit) ? (del_q ? '0 : bg_q) : fg_q;
      plot_d   = del_q || pix_bit || (TRANSPARENT == 0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      shift_q    <= '0;
      char_q     <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      del_q      <= 1'b0;
      rom_addr_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      shift_q    <= shift_d;
      char_q     <= char_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      del_q      <= del_d;
      rom_addr_q <= rom_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_glyph_blitter.sv
// Bench for glyph_blitter: three instances (8x8 opaque, 8x8 transparent, 4x6)
// checked against a raster-order pixel list built from glyph rows.
module tb_glyph_blitter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       go;
  int         sel;
  logic       go_a, go_t, go_s;
  logic [4:0] char_id;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic [2:0] fg_colour, bg_colour;
  logic       del_in;

  logic [7:0] addr_a, addr_t, addr_s, rd_a, rd_t;
  logic [3:0] rd_s;
  logic [7:0] x_a, x_t, x_s;
  logic [6:0] y_a, y_t, y_s;
  logic [2:0] c_a, c_t, c_s;
  logic       plot_a, plot_t, plot_s, busy_a, busy_t, busy_s, done_a, done_t_o, done_s;

  assign go_a = go && (sel == 0);
  assign go_t = go && (sel == 1);
  assign go_s = go && (sel == 2);

  glyph_blitter #(.GLYPH_W(8), .GLYPH_H(8), .TRANSPARENT(0)) dut_a (
    .clk(clk), .resetn(resetn), .go(go_a), .char_id(char_id), .origin_x(origin_x),
    .origin_y(origin_y), .fg_colour(fg_colour), .bg_colour(bg_colour), .delete(del_in),
    .rom_addr(addr_a), .rom_data(rd_a), .vga_x(x_a), .vga_y(y_a), .vga_colour(c_a),
    .plot(plot_a), .busy(busy_a), .done(done_a));

  glyph_blitter #(.GLYPH_W(8), .GLYPH_H(8), .TRANSPARENT(1)) dut_t (
    .clk(clk), .resetn(resetn), .go(go_t), .char_id(char_id), .origin_x(origin_x),
    .origin_y(origin_y), .fg_colour(fg_colour), .bg_colour(bg_colour), .delete(del_in),
    .rom_addr(addr_t), .rom_data(rd_t), .vga_x(x_t), .vga_y(y_t), .vga_colour(c_t),
    .plot(plot_t), .busy(busy_t), .done(done_t_o));

  glyph_blitter #(.GLYPH_W(4), .GLYPH_H(6), .TRANSPARENT(0)) dut_s (
    .clk(clk), .resetn(resetn), .go(go_s), .char_id(char_id), .origin_x(origin_x),
    .origin_y(origin_y), .fg_colour(fg_colour), .bg_colour(bg_colour), .delete(del_in),
    .rom_addr(addr_s), .rom_data(rd_s), .vga_x(x_s), .vga_y(y_s), .vga_colour(c_s),
    .plot(plot_s), .busy(busy_s), .done(done_s));

  // Synchronous font ROMs
  logic [7:0] rom8 [0:255];
  logic [3:0] rom4 [0:255];
  always @(posedge clk) begin
    rd_a <= rom8[addr_a];
    rd_t <= rom8[addr_t];
    rd_s <= rom4[addr_s];
  end

  logic [7:0] x_m, addr_m;
  logic [6:0] y_m;
  logic [2:0] col_m;
  logic       plot_m, busy_m, done_m;
  always_comb begin
    x_m = x_a; y_m = y_a; col_m = c_a; addr_m = addr_a;
    plot_m = plot_a; busy_m = busy_a; done_m = done_a;
    if (sel == 1) begin
      x_m = x_t; y_m = y_t; col_m = c_t; addr_m = addr_t;
      plot_m = plot_t; busy_m = busy_t; done_m = done_t_o;
    end else if (sel == 2) begin
      x_m = x_s; y_m = y_s; col_m = c_s; addr_m = addr_s;
      plot_m = plot_s; busy_m = busy_s; done_m = done_s;
    end
  end

  typedef struct { int x; int y; int c; int t; } pix_t;
  pix_t got_q[$];
  pix_t exp_q[$];
  int   cyc_cnt = 0;
  int   done_cnt = 0;
  int   done_at = 0;
  int   addr_log [0:4095];
  int   e0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: stamps every plot/done with the absolute cycle it was seen in
  always @(negedge clk) begin
    if (plot_m) got_q.push_back('{int'(x_m), int'(y_m), int'(col_m), cyc_cnt});
    if (done_m) begin
      done_cnt = done_cnt + 1;
      done_at  = cyc_cnt;
    end
    addr_log[cyc_cnt % 4096] = int'(addr_m);
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  function automatic int rom_row(input int s, input int a);
    if (s == 2) return int'(rom4[a]);
    return int'(rom8[a]);
  endfunction

  // Reference: every glyph pixel in raster order, with its cycle offset from go
  task automatic build_exp(input int s, input int ch, input int ox, input int oy,
                           input int fg, input int bg, input int del, input int t0);
    int w, h, bitv, row;
    w = (s == 2) ? 4 : 8;
    h = (s == 2) ? 6 : 8;
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      row = rom_row(s, ch * h + r);
      for (int c = 0; c < w; c++) begin
        bitv = (row >> (w - 1 - c)) & 1;
        if (del != 0)
          exp_q.push_back('{(ox + c) % 256, (oy + r) % 128, 0, t0 + r * (w + 2) + 2 + c});
        else if (bitv == 1)
          exp_q.push_back('{(ox + c) % 256, (oy + r) % 128, fg, t0 + r * (w + 2) + 2 + c});
        else if (s != 1)
          exp_q.push_back('{(ox + c) % 256, (oy + r) % 128, bg, t0 + r * (w + 2) + 2 + c});
      end
    end
  endtask

  task automatic run_draw(input int s, input int ch, input int ox, input int oy,
                          input int fg, input int bg, input int del,
                          input int disturb, input int exp_n, input int exp_done);
    int base, dbase, w, h, k, n, bad;
    w = (s == 2) ? 4 : 8;
    h = (s == 2) ? 6 : 8;
    @(negedge clk);
    sel = s;
    char_id = 5'(ch); origin_x = 8'(ox); origin_y = 7'(oy);
    fg_colour = 3'(fg); bg_colour = 3'(bg); del_in = (del != 0);
    go = 1'b1;
    base  = got_q.size();
    dbase = done_cnt;
    @(posedge clk);
    #1;
    go = 1'b0;
    e0 = cyc_cnt;
    chk("busy_after_go", int'(busy_m), 1);
    build_exp(s, ch, ox, oy, fg, bg, del, e0);
    if (disturb != 0) begin
      repeat (14) @(negedge clk);
      char_id = 5'($urandom); origin_x = 8'($urandom); origin_y = 7'($urandom);
      fg_colour = 3'($urandom); del_in = ~del_in;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    k = 0;
    while (done_cnt == dbase && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt == dbase) begin
      failures++;
      $display("FAIL done_timeout actual=no_done required=done");
    end else if (disturb != 0) begin
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
    end
    repeat ((disturb != 0) ? 20 : 3) @(negedge clk);
    #1;
    n = got_q.size() - base;
    chk("done_count", done_cnt - dbase, 1);
    chk("done_cycle", done_at - e0, exp_done);
    chk("busy_idle", int'(busy_m), 0);
    chk("plot_count_model", n, exp_q.size());
    if (exp_n >= 0) chk("plot_count_table", n, exp_n);
    for (int r = 0; r < h; r++)
      chk("rom_addr", addr_log[(e0 + r * (w + 2)) % 4096], ch * h + r);
    bad = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[base + i].x != exp_q[i].x || got_q[base + i].y != exp_q[i].y ||
          got_q[base + i].c != exp_q[i].c || got_q[base + i].t - e0 != exp_q[i].t - e0) begin
        failures++;
        bad++;
        $display("FAIL pixel%0d actual=(%0d,%0d,c%0d,t%0d) required=(%0d,%0d,c%0d,t%0d)", i,
                 got_q[base + i].x, got_q[base + i].y, got_q[base + i].c, got_q[base + i].t - e0,
                 exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].t - e0);
      end
    end
    $display("draw sel=%0d char=%0d org=(%0d,%0d) del=%0d dist=%0d plots=%0d done_at=%0d bad_pix=%0d",
             s, ch, ox, oy, del, disturb, n, done_at - e0, bad);
  endtask

  typedef struct {
    int sel; int ch; int ox; int oy; int fg; int bg; int del; int disturb; int exp_n; int exp_done;
  } vec_t;
  vec_t vecs [0:6];

  initial begin
    int k, base;
    for (int a = 0; a < 256; a++) begin
      rom8[a] = 8'($urandom);
      rom4[a] = 4'($urandom);
    end
    for (int r = 0; r < 8; r++) begin
      rom8[8 + r]  = 8'hFF;
      rom8[16 + r] = (r % 2 == 0) ? 8'hAA : 8'h55;
    end
    vecs[0] = '{0, 1, 10, 20, 7, 0, 0, 0, 64, 80};   // all-ones, opaque
    vecs[1] = '{0, 2, 10, 20, 7, 3, 1, 0, 64, 80};   // erase over checkerboard
    vecs[2] = '{1, 2, 30, 40, 5, 2, 0, 0, 32, 80};   // transparent checkerboard
    vecs[3] = '{0, 1, 252, 125, 6, 1, 0, 0, 64, 80}; // screen-edge wrap
    vecs[4] = '{1, 2, 50, 60, 4, 1, 1, 0, 64, 80};   // erase ignores transparency
    vecs[5] = '{2, 3, 5, 9, 4, 1, 0, 0, 24, 36};     // 4x6 glyph
    vecs[6] = '{0, 2, 100, 50, 3, 6, 0, 1, 64, 80};  // go pulses mid-draw and in DONE

    resetn = 1'b0; go = 1'b0; sel = 0;
    char_id = '0; origin_x = '0; origin_y = '0; fg_colour = '0; bg_colour = '0; del_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_plot", int'(plot_a) + int'(plot_t) + int'(plot_s), 0);
    chk("rst_busy", int'(busy_a) + int'(busy_t) + int'(busy_s), 0);
    chk("rst_done", int'(done_a) + int'(done_t_o) + int'(done_s), 0);
    chk("rst_addr", int'(addr_a) + int'(addr_t) + int'(addr_s), 0);
    chk("rst_x", int'(x_a) + int'(x_t) + int'(x_s), 0);
    chk("rst_y", int'(y_a) + int'(y_t) + int'(y_s), 0);
    chk("rst_colour", int'(c_a) + int'(c_t) + int'(c_s), 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int v = 0; v < 7; v++)
      run_draw(vecs[v].sel, vecs[v].ch, vecs[v].ox, vecs[v].oy, vecs[v].fg, vecs[v].bg,
               vecs[v].del, vecs[v].disturb, vecs[v].exp_n, vecs[v].exp_done);

    // Asynchronous reset part-way through a glyph
    @(negedge clk);
    sel = 0; char_id = 5'd1; origin_x = 8'd10; origin_y = 7'd20; del_in = 1'b0;
    fg_colour = 3'd7; go = 1'b1;
    base = got_q.size();
    @(posedge clk);
    #1;
    go = 1'b0;
    k = 0;
    while (got_q.size() - base < 30 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reached_pixel30", got_q.size() - base, 30);
    resetn = 1'b0;
    #1;
    chk("midrst_plot", int'(plot_m), 0);
    chk("midrst_busy", int'(busy_m), 0);
    chk("midrst_done", int'(done_m), 0);
    chk("midrst_addr", int'(addr_m), 0);
    @(negedge clk);
    resetn = 1'b1;
    run_draw(0, 1, 10, 20, 7, 0, 0, 0, 64, 80);

    for (int i = 0; i < 25; i++) begin
      int s;
      s = $urandom_range(0, 2);
      run_draw(s, $urandom_range(0, 31), $urandom_range(0, 255), $urandom_range(0, 127),
               $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 1 : 0,
               0, -1, (s == 2) ? 36 : 80);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
